// File: rtl/detect_event_logger.sv
// rtl/detect_event_logger.sv - timestamps detector hits into a small FWFT FIFO with event counter and overflow flag
module detect_event_logger #(
    parameter int TS_WIDTH  = 16,
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     clear,
    input  logic                     detect,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [TS_WIDTH-1:0]      rd_data,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_WIDTH-1:0]     evt_count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [TS_WIDTH-1:0] ts;
    logic [TS_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW-1:0]       rd_ptr_next;
    logic [LW-1:0]       level_next;
    logic [TS_WIDTH-1:0] head_next;
    logic                evt;
    logic                pop;
    logic                full;
    logic                push;
    logic                drop;

    assign rd_valid = (fifo_level != '0);

    // Decide push/pop/drop for this edge and precompute the head entry that rd_data
    // must show afterwards; a push landing in the new head slot is forwarded from ts.
    always_comb begin
        evt         = enable & detect;
        pop         = rd_valid & rd_ready;
        full        = (fifo_level == LW'(DEPTH));
        push        = evt & (~full | pop);
        drop        = evt & full & ~pop;
        rd_ptr_next = pop ? rd_ptr + AW'(1) : rd_ptr;
        level_next  = fifo_level + LW'(push) - LW'(pop);
        head_next   = (push && (wr_ptr == rd_ptr_next)) ? ts : mem[rd_ptr_next];
    end

    // Entry storage; no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (!reset && !clear && push) begin
            mem[wr_ptr] <= ts;
        end
    end

    // Timestamp, pointers, occupancy, registered head, event counter and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            ts         <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            rd_data    <= '0;
            evt_count  <= '0;
            overflow   <= 1'b0;
        end else if (clear) begin
            // rd_data keeps its last value, as it does whenever the FIFO is empty
            ts         <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            evt_count  <= '0;
            overflow   <= 1'b0;
        end else begin
            if (enable) begin
                ts <= ts + TS_WIDTH'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr     <= rd_ptr_next;
            fifo_level <= level_next;
            if (level_next != '0) begin
                rd_data <= head_next;
            end
            if (evt && (evt_count != '1)) begin
                evt_count <= evt_count + CNT_WIDTH'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_detect_event_logger.sv
// tb/tb_detect_event_logger.sv - self-checking bench for detect_event_logger
module tb_detect_event_logger;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, enable, clear, detect, rd_ready;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic [2:0]  fifo_level;
    logic [7:0]  evt_count;
    logic        overflow;

    detect_event_logger #(.TS_WIDTH(16), .DEPTH(DEPTH), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .detect(detect),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .fifo_level(fifo_level), .evt_count(evt_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model: queue of logged timestamps plus scalar state
    int q[$];
    int m_ts, m_cnt, m_last;
    bit m_ovf;

    typedef struct packed {
        logic       en;
        logic       det;
        logic       rdy;
        logic       exp_valid;
        logic [15:0] exp_data;
        logic [2:0] exp_level;
        logic [7:0] exp_cnt;
        logic       exp_ovf;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model(input bit r, input bit e, input bit c, input bit d, input bit y);
        bit ev;
        ev = e && d;
        if (r) begin
            q.delete(); m_ts = 0; m_cnt = 0; m_ovf = 0; m_last = 0;
        end else if (c) begin
            q.delete(); m_ts = 0; m_cnt = 0; m_ovf = 0;
        end else begin
            if (q.size() > 0 && y) void'(q.pop_front());
            if (ev) begin
                if (m_cnt < 255) m_cnt++;
                if (q.size() < DEPTH) q.push_back(m_ts);
                else m_ovf = 1;
            end
            if (e) m_ts = (m_ts + 1) % 65536;
            if (q.size() > 0) m_last = q[0];
        end
    endtask

    task automatic apply(input bit r, input bit e, input bit c, input bit d, input bit y);
        reset = r; enable = e; clear = c; detect = d; rd_ready = y;
        model(r, e, c, d, y);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".valid"}, int'(rd_valid), (q.size() > 0) ? 1 : 0);
        chk({tag, ".data"},  int'(rd_data), m_last);
        chk({tag, ".level"}, int'(fifo_level), q.size());
        chk({tag, ".cnt"},   int'(evt_count), m_cnt);
        chk({tag, ".ovf"},   int'(overflow), int'(m_ovf));
    endtask

    task automatic pop_check(input string tag, input int exp);
        chk({tag, ".valid"}, int'(rd_valid), 1);
        chk({tag, ".data"}, int'(rd_data), exp);
        apply(0, 0, 0, 0, 1);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; clear = 1'b0; detect = 1'b0; rd_ready = 1'b0;

        for (int i = 0; i < 5; i++) tbl[i] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 3'd0, 8'd0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd5,  3'd1, 8'd1, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'd5,  3'd0, 8'd1, 1'b0};
        for (int i = 7; i < 10; i++) tbl[i] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd5, 3'd0, 8'd1, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd10, 3'd1, 8'd2, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd10, 3'd2, 8'd3, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd10, 3'd3, 8'd4, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'd11, 3'd2, 8'd4, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'd12, 3'd1, 8'd4, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd12, 3'd0, 8'd4, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd12, 3'd0, 8'd4, 1'b0};
        tbl[17] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd13, 3'd1, 8'd5, 1'b0};

        // reset state
        apply(1, 0, 0, 0, 0);
        chk("reset.valid", int'(rd_valid), 0);
        chk("reset.data", int'(rd_data), 0);
        chk("reset.level", int'(fifo_level), 0);
        chk("reset.cnt", int'(evt_count), 0);
        chk("reset.ovf", int'(overflow), 0);

        // table: single event at ts=5, pop, burst 10..12, drain while paused, frozen ts
        for (int i = 0; i < 18; i++) begin
            apply(0, tbl[i].en, 0, tbl[i].det, tbl[i].rdy);
            chk($sformatf("tbl%0d.valid", i), int'(rd_valid), int'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d.data", i), int'(rd_data), int'(tbl[i].exp_data));
            chk($sformatf("tbl%0d.level", i), int'(fifo_level), int'(tbl[i].exp_level));
            chk($sformatf("tbl%0d.cnt", i), int'(evt_count), int'(tbl[i].exp_cnt));
            chk($sformatf("tbl%0d.ovf", i), int'(overflow), int'(tbl[i].exp_ovf));
        end

        // burst of 3 from ts=10 with no reader
        apply(1, 0, 0, 0, 0);
        repeat (10) apply(0, 1, 0, 0, 0);
        repeat (3) apply(0, 1, 0, 1, 0);
        chk("burst.level", int'(fifo_level), 3);
        chk("burst.cnt", int'(evt_count), 3);
        for (int i = 0; i < 3; i++) pop_check("burst.pop", 10 + i);
        chk("burst.empty", int'(rd_valid), 0);

        // overflow: 6 events into 4 entries
        apply(1, 0, 0, 0, 0);
        repeat (6) apply(0, 1, 0, 1, 0);
        chk("ovf.level", int'(fifo_level), 4);
        chk("ovf.flag", int'(overflow), 1);
        chk("ovf.cnt", int'(evt_count), 6);
        for (int i = 0; i < 4; i++) pop_check("ovf.pop", i);
        chk("ovf.empty", int'(rd_valid), 0);
        chk("ovf.sticky", int'(overflow), 1);

        // full FIFO with simultaneous push and pop
        apply(1, 0, 0, 0, 0);
        repeat (4) apply(0, 1, 0, 1, 0);
        apply(0, 1, 0, 1, 1);
        chk("fullpp.level", int'(fifo_level), 4);
        chk("fullpp.ovf", int'(overflow), 0);
        chk("fullpp.cnt", int'(evt_count), 5);
        for (int i = 0; i < 4; i++) pop_check("fullpp.pop", 1 + i);

        // timestamp wrap
        apply(1, 0, 0, 0, 0);
        repeat (65534) apply(0, 1, 0, 0, 0);
        repeat (3) apply(0, 1, 0, 1, 0);
        pop_check("wrap.pop0", 16'hFFFE);
        pop_check("wrap.pop1", 16'hFFFF);
        pop_check("wrap.pop2", 0);

        // counter saturation, then clear together with detect
        apply(1, 0, 0, 0, 0);
        repeat (300) apply(0, 1, 0, 1, 0);
        chk("sat.cnt", int'(evt_count), 255);
        chk("sat.ovf", int'(overflow), 1);
        chk("sat.level", int'(fifo_level), 4);
        apply(0, 1, 1, 1, 1);
        chk("clr.cnt", int'(evt_count), 0);
        chk("clr.level", int'(fifo_level), 0);
        chk("clr.ovf", int'(overflow), 0);
        chk("clr.valid", int'(rd_valid), 0);
        apply(0, 1, 0, 1, 0);
        chk("clr.ts0.valid", int'(rd_valid), 1);
        chk("clr.ts0.data", int'(rd_data), 0);
        chk("clr.ts0.cnt", int'(evt_count), 1);

        // randomized traffic against the reference model, including mid-stream reset/clear
        apply(1, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            apply($urandom_range(99) < 1, $urandom_range(3) != 0, $urandom_range(99) < 2,
                  $urandom_range(1) == 1, $urandom_range(1) == 1);
            chk_model($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/detect_event_logger.md
Name: detect_event_logger

Overview:
- Sits directly downstream of the two-sequence detector.
- Consumes its one-cycle `detect` output and timestamps every detection against a free-running cycle counter.
- Buffers the timestamps in a small FIFO, drained by a valid/ready read port, so that a host or UART stage can read event times without losing back-to-back hits.
- Also keeps a saturating total-event counter and a sticky overflow flag.

Parameters:
- TS_WIDTH, 16, width of the timestamp counter and of each logged entry.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_WIDTH, 8, width of the saturating total-event counter.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- enable  in  1  1 = timestamp counter runs and detect is sampled; 0 = both frozen.
- clear  in  1  synchronous one-cycle flush of the FIFO, counters and overflow.
- detect  in  1  detection pulse from the sequence detector, sampled every cycle.
- rd_valid  out  1  FIFO not empty; rd_data holds the oldest entry.
- rd_ready  in  1  consumer accepts rd_data this cycle.
- rd_data  out  TS_WIDTH  timestamp of the oldest unread event.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- evt_count  out  CNT_WIDTH  total events seen, including dropped ones; saturating.
- overflow  out  1  sticky; set when an event is dropped because the FIFO is full.

Behaviour:
- Reset (reset=1 at an edge):
  - ts=0, FIFO empty (rd_valid=0, fifo_level=0), rd_data=0, evt_count=0, overflow=0.
  - Reset overrides every other input, including a mid-stream burst.
- clear=1 at an edge: same effect as reset on ts, FIFO, evt_count and overflow. Any detect or pop in that cycle is discarded.
- Timestamp ts:
  - Internal register; increments by 1 each edge with enable=1 and holds while enable=0.
  - Wraps modulo 2^TS_WIDTH (0xFFFF -> 0x0000 at default).
- Event:
  - Occurs when detect=1 and enable=1 at an edge. The entry logged is the ts value present in that cycle, i.e. before the increment.
  - detect high for k consecutive cycles produces k events with consecutive timestamps (level-sampled, no edge detection).
- Push:
  - An event is written at the tail if fifo_level<DEPTH, or if fifo_level==DEPTH and a pop occurs in the same cycle.
  - Otherwise the event is dropped and overflow is set to 1; overflow clears only on reset or clear.
- Pop:
  - Occurs when rd_valid=1 and rd_ready=1 at an edge; the head advances.
  - rd_ready while rd_valid=0 has no effect.
- Read port:
  - First-word-fall-through from registered storage. rd_data = head entry while rd_valid=1, and holds its last value while empty.
  - rd_valid and rd_data stay stable until popped.
- Latency: an event at edge N gives rd_valid=1 in the cycle after edge N. There is no same-cycle bypass when empty.
- Simultaneous push and pop:
  - Non-empty, non-full FIFO: level unchanged, order preserved.
  - Full FIFO: the push is accepted, level stays DEPTH, overflow is not set.
- Pointers:
  - Read and write pointers are log2(DEPTH) bits and wrap naturally.
  - fifo_level is tracked separately or derived from an extra pointer bit; it must equal the exact occupancy every cycle.
- evt_count:
  - +1 on every event, whether pushed or dropped.
  - Saturates at 2^CNT_WIDTH-1 and does not wrap.
- enable=0:
  - ts frozen and detect ignored.
  - Pops still allowed, so the consumer can drain the FIFO while logging is paused.

Test Plan:
- Reset, then enable=1; detect=1 at ts=5 (one cycle) -> rd_valid=1 next cycle, rd_data=5, fifo_level=1; pop with rd_ready=1 -> rd_valid=0, fifo_level=0.
- detect held high for 3 cycles starting at ts=10, rd_ready=0 -> FIFO holds 10, 11, 12 in order, fifo_level=3, evt_count=3.
- 6 detects with rd_ready=0 (DEPTH=4) -> fifo_level=4, overflow=1, evt_count=6; pops return the first 4 timestamps only.
- FIFO full, detect=1 and rd_ready=1 in the same cycle -> level stays 4, overflow stays 0, new ts enters at the tail.
- Preload ts to 0xFFFE (run 65534 cycles) and detect on 3 consecutive cycles -> entries 0xFFFE, 0xFFFF, 0x0000.
- 300 detects with CNT_WIDTH=8 -> evt_count=255. Then clear=1 together with detect=1 -> evt_count=0, fifo_level=0, overflow=0, ts=0, no entry logged.
